i2c_master_tx: RTL and testbench
================================

I2C_MASTER_TX -- requirements
Module: i2c_master_tx

Interface
REQ-001 Parameter QUARTER_CYCLES, default 250, sets clk cycles per SCL quarter-period (100 kHz SCL at 100 MHz clk); legal values are >= 4.
REQ-002 Parameter SLAVE_ADDR, default 7'h55, is the 7-bit target address.
REQ-003 clk  input  1  system clock; all logic on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  request a write transaction; accepted only when busy=0.
REQ-006 num_bytes  input  3  data bytes to send; 0 means address-only, values above 5 clamp to 5.
REQ-007 tx_data0..tx_data4  input  8 each  payload bytes, sent in order 0 to 4.
REQ-008 i2c_scl  output  1  push-pull SCL; high when idle.
REQ-009 i2c_sda  inout  1  open-drain SDA; drives only 0, otherwise high-Z.
REQ-010 busy  output  1  high while a transaction is in progress.
REQ-011 done  output  1  one-cycle pulse when a transaction completes.
REQ-012 ack_err  output  1  sticky NACK flag; cleared when the next start is accepted.

Function
REQ-013 Accept: on start=1 with busy=0, latch num_bytes and tx_data0..4, clear ack_err, and raise busy on the next cycle; start while busy=1 is ignored.
REQ-014 Timing base: a quarter-tick counter runs only while busy; every phase below lasts an integer number of quarters.
REQ-015 FSM states: IDLE, START, ADDR, ADDR_ACK, DATA, DATA_ACK, STOP, DONE.
REQ-016 START (2 quarters): 1st quarter SCL=1, SDA released; 2nd quarter SCL=1, SDA=0.
REQ-017 Bit cell (4 quarters): Q0 SCL=0 and SDA set to the bit, MSB first; Q1 SCL=0; Q2 SCL=1; Q3 SCL=1.
REQ-018 ADDR: shifts out {SLAVE_ADDR, 1'b0} (write) as 8 bit cells, then goes to ADDR_ACK.
REQ-019 ADDR_ACK and DATA_ACK: one bit cell with SDA released; SDA, through a 2-FF synchronizer, is sampled on the last clk of Q2; 0 is ACK, 1 is NACK.
REQ-020 On ACK: go to DATA if bytes remain, else go to STOP.
REQ-021 On NACK: set ack_err and go to STOP; no further bytes are sent.
REQ-022 DATA: sends tx_data[byte_idx] as 8 bit cells, then goes to DATA_ACK; byte_idx increments after each DATA_ACK.
REQ-023 STOP (4 quarters): SCL=0/SDA=0; SCL=1/SDA=0; SCL=1/SDA released; then one bus-free quarter with SCL=1 and SDA released.
REQ-024 DONE: pulse done for one cycle, drop busy in the same cycle, return to IDLE.
REQ-025 Duration: with N bytes and no NACK, busy stays high for exactly (6+36*(N+1))*QUARTER_CYCLES cycles.
REQ-026 SDA changes only while SCL=0, except in the START and STOP edges.

Reset
REQ-027 Reset, including mid-transaction, forces IDLE, i2c_scl=1, SDA high-Z, busy=0, done=0, ack_err=0, all counters to 0, and latched data to 0 within the same cycle (asynchronous).

Structure
REQ-028 Shared package i2c_pkg holds the master state enum, the I2C_SLV_ADDR=7'h55 constant and the MAX_BYTES=5 constant; the address constant is shared with the existing slave.
REQ-029 Optional sub-module i2c_quarter_tick produces the quarter-tick enable and the 2-bit quarter index.

Verification
REQ-030 Bench contains the team's I2C slave at address 0x55 and an SCL/SDA pull-up model.
REQ-031 Scenario 1: QUARTER_CYCLES=4, num_bytes=5, data 11,22,33,44,55 -> slave regs 0..4 equal 11..55, ack_err=0, busy high for exactly 888 cycles, one done pulse.
REQ-032 Scenario 2: SLAVE_ADDR=7'h23 -> slave NACKs the address, ack_err=1, STOP is issued, no slave reg changes.
REQ-033 Scenario 3: num_bytes=0 -> address plus STOP only, done after 168 cycles (Q=4), ack_err=0.
REQ-034 Scenario 4: num_bytes=7, data A1..A5 -> exactly 5 bytes sent and STOP issued.
REQ-035 Scenario 5: start pulsed again while busy -> ignored, a single transaction, one done pulse.
REQ-036 Scenario 6: reset asserted during byte 2 -> SCL=1 and SDA high-Z immediately; a subsequent start completes normally.

Source files
------------

// File: rtl/i2c_pkg.sv
// i2c_pkg: state encoding and bus constants shared by the I2C master and the existing slave.
package i2c_pkg;
   localparam logic [6:0] I2C_SLV_ADDR = 7'h55;
   localparam int MAX_BYTES = 5;
   typedef enum logic [2:0] {IDLE, START, ADDR, ADDR_ACK, DATA, DATA_ACK, STOP, DONE} mstate_t;
endpackage

// File: rtl/i2c_quarter_tick.sv
// i2c_quarter_tick: SCL quarter-period enable and 2-bit quarter index.
module i2c_quarter_tick #(
   parameter int QUARTER_CYCLES = 250
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       i_en,
   input  logic       i_load,
   output logic       o_tick,
   output logic [1:0] o_qidx
);
   localparam int CW = $clog2(QUARTER_CYCLES);
   logic [CW-1:0] r_cnt;
   logic [1:0]    r_qidx;
   assign o_tick = i_en && (r_cnt == CW'(QUARTER_CYCLES - 1));
   assign o_qidx = r_qidx;
   // A transaction opens at quarter 2 so the 2-quarter START leaves every later cell aligned to 0.
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         r_cnt  <= '0;
         r_qidx <= '0;
      end else if (i_load) begin
         r_cnt  <= '0;
         r_qidx <= 2'd2;
      end else if (!i_en) begin
         r_cnt  <= '0;
         r_qidx <= '0;
      end else if (o_tick) begin
         r_cnt  <= '0;
         r_qidx <= r_qidx + 2'd1;
      end else
         r_cnt <= r_cnt + 1'b1;
endmodule

// File: rtl/i2c_master_tx.sv
// i2c_master_tx: write-only I2C master sending an address plus up to five payload bytes.
module i2c_master_tx import i2c_pkg::*; #(
   parameter int         QUARTER_CYCLES = 250,
   parameter logic [6:0] SLAVE_ADDR     = I2C_SLV_ADDR
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic [2:0] num_bytes,
   input  logic [7:0] tx_data0,
   input  logic [7:0] tx_data1,
   input  logic [7:0] tx_data2,
   input  logic [7:0] tx_data3,
   input  logic [7:0] tx_data4,
   output logic       i2c_scl,
   inout  wire        i2c_sda,
   output logic       busy,
   output logic       done,
   output logic       ack_err
);
   mstate_t    r_state, w_next;
   logic [2:0] r_num, r_idx, r_bit, w_nidx;
   logic [7:0] r_sh;
   logic [7:0] r_data [MAX_BYTES];
   logic       r_nack, r_ack_err, r_sda_s1, r_sda_s2;
   logic       w_tick, w_accept, w_cell_end, w_more, w_sda_low, w_ack;
   logic [1:0] w_qidx;
   i2c_quarter_tick #(.QUARTER_CYCLES(QUARTER_CYCLES)) u_qt (
      .clk(clk), .reset(reset), .i_en(busy), .i_load(w_accept), .o_tick(w_tick), .o_qidx(w_qidx)
   );
   assign busy       = (r_state != IDLE) && (r_state != DONE);
   assign done       = r_state == DONE;
   assign ack_err    = r_ack_err;
   assign w_accept   = start && !busy;
   assign w_cell_end = w_tick && (w_qidx == 2'd3);
   assign w_ack      = (r_state == ADDR_ACK) || (r_state == DATA_ACK);
   assign w_nidx     = (r_state == DATA_ACK) ? r_idx + 3'd1 : r_idx;
   assign w_more     = w_nidx < r_num;
   assign i2c_sda    = w_sda_low ? 1'b0 : 1'bz;
   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE, DONE:         w_next = start ? START : IDLE;
         START:              w_next = w_cell_end ? ADDR : START;
         ADDR:               w_next = (w_cell_end && r_bit == 3'd7) ? ADDR_ACK : ADDR;
         DATA:               w_next = (w_cell_end && r_bit == 3'd7) ? DATA_ACK : DATA;
         ADDR_ACK, DATA_ACK: w_next = !w_cell_end ? r_state : (!r_nack && w_more) ? DATA : STOP;
         STOP:               w_next = w_cell_end ? DONE : STOP;
         default:            w_next = IDLE;
      endcase
   end
   always_comb begin
      i2c_scl   = 1'b1;
      w_sda_low = 1'b0;
      case (r_state)
         START: w_sda_low = w_qidx == 2'd3;
         ADDR, DATA: begin
            i2c_scl   = w_qidx[1];
            w_sda_low = !r_sh[7];
         end
         ADDR_ACK, DATA_ACK: i2c_scl = w_qidx[1];
         STOP: begin
            i2c_scl   = w_qidx != 2'd0;
            w_sda_low = !w_qidx[1];
         end
         default: ;
      endcase
   end
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         r_state   <= IDLE;
         r_num     <= '0;
         r_idx     <= '0;
         r_bit     <= '0;
         r_sh      <= '0;
         r_nack    <= 1'b0;
         r_ack_err <= 1'b0;
         r_sda_s1  <= 1'b1;
         r_sda_s2  <= 1'b1;
         for (int i = 0; i < MAX_BYTES; i++) r_data[i] <= '0;
      end else begin
         r_state  <= w_next;
         r_sda_s1 <= i2c_sda;
         r_sda_s2 <= r_sda_s1;
         if (w_accept) begin
            r_num     <= (num_bytes > 3'(MAX_BYTES)) ? 3'(MAX_BYTES) : num_bytes;
            r_data[0] <= tx_data0;
            r_data[1] <= tx_data1;
            r_data[2] <= tx_data2;
            r_data[3] <= tx_data3;
            r_data[4] <= tx_data4;
            r_ack_err <= 1'b0;
            r_idx     <= '0;
            r_bit     <= '0;
         end
         if (r_state == START && w_cell_end) r_sh <= {SLAVE_ADDR, 1'b0};
         if ((r_state == ADDR || r_state == DATA) && w_cell_end) begin
            r_sh  <= {r_sh[6:0], 1'b0};
            r_bit <= r_bit + 3'd1;
         end
         // Synchronized SDA captured on the final clk of the SCL-high Q2.
         if (w_ack && w_tick && w_qidx == 2'd2) r_nack <= r_sda_s2;
         if (w_ack && w_cell_end) begin
            if (r_nack) r_ack_err <= 1'b1;
            if (r_state == DATA_ACK) r_idx <= r_idx + 3'd1;
            if (!r_nack && w_more) r_sh <= r_data[w_nidx];
         end
      end
endmodule

// File: tb/tb_i2c_master_tx.sv
// tb_i2c_master_tx: two masters (addr 0x55 and 0x23) on separate pulled-up buses,
// one behavioural slave at 0x55, scoreboard of per-transaction expectations.
`timescale 1ns/1ps
module tb_i2c_master_tx;
   localparam int Q = 4;
   typedef struct {
      int          cycles;
      logic        err;
      int          nbytes;
      logic [39:0] regs;
   } exp_t;
   logic       clk = 1'b0, reset = 1'b1, start_a = 1'b0, start_b = 1'b0, sel = 1'b0;
   logic [2:0] num_bytes = '0;
   logic [7:0] td [5] = '{default: 8'h00};
   wire        scl_a, scl_b, sda_a, sda_b;
   logic       busy_a, busy_b, done_a, done_b, err_a, err_b;
   pullup (sda_a);
   pullup (sda_b);
   always #5 clk = ~clk;
   i2c_master_tx #(.QUARTER_CYCLES(Q)) u_dut_a (
      .clk(clk), .reset(reset), .start(start_a), .num_bytes(num_bytes),
      .tx_data0(td[0]), .tx_data1(td[1]), .tx_data2(td[2]), .tx_data3(td[3]), .tx_data4(td[4]),
      .i2c_scl(scl_a), .i2c_sda(sda_a), .busy(busy_a), .done(done_a), .ack_err(err_a)
   );
   i2c_master_tx #(.QUARTER_CYCLES(Q), .SLAVE_ADDR(7'h23)) u_dut_b (
      .clk(clk), .reset(reset), .start(start_b), .num_bytes(num_bytes),
      .tx_data0(td[0]), .tx_data1(td[1]), .tx_data2(td[2]), .tx_data3(td[3]), .tx_data4(td[4]),
      .i2c_scl(scl_b), .i2c_sda(sda_b), .busy(busy_b), .done(done_b), .ack_err(err_b)
   );
   // Slave sits on whichever bus sel picks; it drives SDA low only to acknowledge.
   logic       slv_low = 1'b0, ps = 1'b1, pd = 1'b1, sl_act = 1'b0, sl_addr = 1'b0, sl_hit = 1'b0;
   logic [7:0] sl_sh = '0;
   logic [7:0] sl_regs [5] = '{default: 8'h00};
   int         sl_bit = 0, sl_widx = 0, n_starts = 0, n_stops = 0;
   wire        s_scl = sel ? scl_b : scl_a;
   wire        s_sda = sel ? sda_b : sda_a;
   assign sda_a = (!sel && slv_low) ? 1'b0 : 1'bz;
   assign sda_b = (sel && slv_low) ? 1'b0 : 1'bz;
   always @(posedge clk) begin
      ps <= s_scl;
      pd <= s_sda;
      if (s_scl && ps && pd && !s_sda) begin
         n_starts <= n_starts + 1;
         sl_act   <= 1'b1;
         sl_addr  <= 1'b1;
         sl_hit   <= 1'b0;
         sl_bit   <= 0;
         sl_widx  <= 0;
         slv_low  <= 1'b0;
      end else if (s_scl && ps && !pd && s_sda) begin
         n_stops <= n_stops + 1;
         sl_act  <= 1'b0;
         slv_low <= 1'b0;
      end else if (sl_act && s_scl && !ps && sl_bit < 8) begin
         sl_sh  <= {sl_sh[6:0], s_sda};
         sl_bit <= sl_bit + 1;
      end else if (sl_act && !s_scl && ps) begin
         if (sl_bit == 8) begin
            sl_bit <= 9;
            if (sl_addr) begin
               sl_hit  <= sl_sh == {7'h55, 1'b0};
               slv_low <= sl_sh == {7'h55, 1'b0};
            end else begin
               slv_low <= 1'b1;
               if (sl_widx < 5) sl_regs[sl_widx] <= sl_sh;
               sl_widx <= sl_widx + 1;
            end
         end else if (sl_bit == 9) begin
            slv_low <= 1'b0;
            sl_bit  <= 0;
            sl_addr <= 1'b0;
            sl_act  <= sl_hit;
         end
      end
   end
   int          n_checks = 0, n_pass = 0, n_done = 0, n_exp_done = 0;
   exp_t        sb [$];
   logic [7:0]  m_regs [5] = '{default: 8'h00};
   task automatic chk(input string nm, input longint act, input longint req);
      n_checks++;
      if (act == req) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, req, $time);
   endtask
   function automatic logic [39:0] pack5(input logic [7:0] r [5]);
      logic [39:0] p;
      for (int i = 0; i < 5; i++) p[8*i +: 8] = r[i];
      return p;
   endfunction
   // Monitor: measures busy length and pops one expectation per done pulse.
   wire  m_busy = sel ? busy_b : busy_a;
   wire  m_done = sel ? done_b : done_a;
   wire  m_err  = sel ? err_b : err_a;
   logic pbusy = 1'b0;
   int   bcnt = 0, base_st = 0, base_sp = 0;
   always @(negedge clk) begin
      exp_t e;
      if (m_busy && !pbusy) begin
         base_st = n_starts;
         base_sp = n_stops;
      end
      pbusy = m_busy;
      if (m_busy) bcnt++;
      if (m_done) begin
         n_done++;
         if (sb.size() == 0) chk("extra_done", 1, 0);
         else begin
            e = sb.pop_front();
            chk("busy_cycles", bcnt, e.cycles);
            chk("ack_err", m_err, e.err);
            chk("bytes_written", sl_widx, e.nbytes);
            chk("slave_regs", pack5(sl_regs), e.regs);
            chk("start_conds", n_starts - base_st, 1);
            chk("stop_conds", n_stops - base_sp, 1);
         end
         bcnt = 0;
      end else if (!m_busy) bcnt = 0;
   end
   task automatic issue(input logic b, input logic [2:0] nb, input logic [39:0] d);
      exp_t e;
      int   n;
      logic hit;
      sel       = b;
      num_bytes = nb;
      for (int i = 0; i < 5; i++) td[i] = d[8*i +: 8];
      hit      = (b ? 7'h23 : 7'h55) == 7'h55;
      n        = (nb > 3'd5) ? 5 : int'(nb);
      e.err    = !hit;
      e.nbytes = hit ? n : 0;
      e.cycles = (6 + 36 * (e.nbytes + 1)) * Q;
      for (int i = 0; i < e.nbytes; i++) m_regs[i] = d[8*i +: 8];
      e.regs   = pack5(m_regs);
      sb.push_back(e);
      n_exp_done++;
      @(negedge clk);
      if (b) start_b = 1'b1;
      else start_a = 1'b1;
      @(negedge clk);
      start_a = 1'b0;
      start_b = 1'b0;
   endtask
   task automatic wait_done();
      int d0, k;
      d0 = n_done;
      k  = 0;
      while (n_done == d0 && k < 3000) begin
         @(negedge clk);
         k++;
      end
      chk("done_seen", n_done - d0, 1);
      repeat (20) @(negedge clk);
   endtask
   function automatic logic [39:0] rnd40();
      return {8'($urandom()), 32'($urandom())};
   endfunction
   initial begin
      #1ms;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1);
   end
   initial begin
      logic [39:0] d;
      logic [7:0]  saved [5];
      repeat (3) @(negedge clk);
      chk("rst_scl", scl_a, 1);
      chk("rst_sda", sda_a, 1);
      chk("rst_busy", busy_a, 0);
      chk("rst_done", done_a, 0);
      chk("rst_ack_err", err_a, 0);
      reset = 1'b0;
      @(negedge clk);
      issue(1'b0, 3'd5, 40'h55_44_33_22_11);
      wait_done();
      issue(1'b1, 3'd3, rnd40());
      wait_done();
      chk("ack_err_sticky", err_b, 1);
      issue(1'b1, 3'd1, rnd40());
      chk("ack_err_clear", err_b, 0);
      wait_done();
      issue(1'b0, 3'd0, rnd40());
      wait_done();
      issue(1'b0, 3'd7, 40'hA5_A4_A3_A2_A1);
      wait_done();
      issue(1'b0, 3'd2, rnd40());
      repeat (100) @(negedge clk);
      start_a = 1'b1;
      @(negedge clk);
      start_a = 1'b0;
      wait_done();
      repeat (200) @(negedge clk);
      saved = m_regs;
      d = rnd40();
      issue(1'b0, 3'd4, d);
      repeat (86 * Q - 1) @(negedge clk);
      #1 reset = 1'b1;
      #1;
      chk("abort_scl", scl_a, 1);
      chk("abort_sda", sda_a, 1);
      chk("abort_busy", busy_a, 0);
      void'(sb.pop_back());
      n_exp_done--;
      m_regs    = saved;
      m_regs[0] = d[7:0];
      repeat (5) @(negedge clk);
      reset = 1'b0;
      repeat (5) @(negedge clk);
      chk("abort_regs", pack5(sl_regs), pack5(m_regs));
      issue(1'b0, 3'd5, rnd40());
      wait_done();
      for (int t = 0; t < 6; t++) begin
         issue(1'($urandom_range(0, 3) == 0), 3'($urandom_range(0, 7)), rnd40());
         wait_done();
      end
      chk("queue_empty", sb.size(), 0);
      chk("done_count", n_done, n_exp_done);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
